// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared types and encodings for the control pipeline.
//   ctrl_t       - decoded control bundle as it travels down the pipeline
//   CTRL_BUBBLE  - all-zero bundle inserted on stall, flush or reset
//   alu_op_t     - ALU operation encodings carried in the bundle
//   fwd_sel_t    - operand forward-select encodings
//   fwd_select() - forwarding priority rule shared by both ALU operands
package ctrl_pipe_pkg;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'b000,
    ALUOP_SUB   = 3'b001,
    ALUOP_RTYPE = 3'b010,
    ALUOP_OR    = 3'b011,
    ALUOP_SLT   = 3'b100,
    ALUOP_JUMP  = 3'b111
  } alu_op_t;

  // Field order matches the flat ID-stage bundle, MSB first.
  typedef struct packed {
    logic    reg_dst;
    logic    mem_read;
    logic    memto_reg;
    logic    mem_write;
    logic    alu_src;
    logic    reg_write;
    logic    beq;
    logic    bne;
    alu_op_t alu_op;
  } ctrl_t;

  localparam int    CTRL_W      = $bits(ctrl_t);
  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  // The younger result (MEM) wins over the older one (WB); $0 is never forwarded.
  function automatic fwd_sel_t fwd_select(input logic       mem_reg_write,
                                          input logic [4:0] mem_wreg,
                                          input logic       wb_reg_write,
                                          input logic [4:0] wb_wreg,
                                          input logic [4:0] src);
    fwd_sel_t sel;
    sel = FWD_NONE;
    if (mem_reg_write && (mem_wreg != 5'd0) && (mem_wreg == src))
      sel = FWD_MEM;
    else if (wb_reg_write && (wb_wreg != 5'd0) && (wb_wreg == src))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: bundles every ctrl_pipe signal except clock and reset.
//   ID side   : id_ctrl, id_rs, id_rt, id_rd, ex_zero        (master -> slave)
//   EX side   : ex_ALUOp, ex_ALUSrc, ex_rs, ex_rt            (slave -> master)
//   MEM/WB    : mem_memRead, mem_memWrite, wb_regWrite,
//               wb_memtoReg, wb_wreg                         (slave -> master)
//   hazards   : stall, flush, fwd_a, fwd_b,
//               stall_cnt, flush_cnt                         (slave -> master)
// The slave modport is the pipeline itself; the master is whoever feeds it.
interface ctrl_pipe_if;
  import ctrl_pipe_pkg::*;

  logic [CTRL_W-1:0] id_ctrl;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic              ex_zero;

  logic [2:0]        ex_ALUOp;
  logic              ex_ALUSrc;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;

  logic              mem_memRead;
  logic              mem_memWrite;
  logic              wb_regWrite;
  logic              wb_memtoReg;
  logic [4:0]        wb_wreg;

  logic              stall;
  logic              flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  modport master (
    output id_ctrl, id_rs, id_rt, id_rd, ex_zero,
    input  ex_ALUOp, ex_ALUSrc, ex_rs, ex_rt,
    input  mem_memRead, mem_memWrite, wb_regWrite, wb_memtoReg, wb_wreg,
    input  stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_ctrl, id_rs, id_rt, id_rd, ex_zero,
    output ex_ALUOp, ex_ALUSrc, ex_rs, ex_rt,
    output mem_memRead, mem_memWrite, wb_regWrite, wb_memtoReg, wb_wreg,
    output stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/ctrl_pipe_hazard_unit.sv
// hazard_unit: purely combinational load-use, branch and forwarding logic.
//   inputs : EX-stage bundle bits and specifiers, ID-stage specifiers,
//            ALU zero flag, MEM/WB write-enable and destination register
//   outputs: stall, flush (flush has priority), fwd_a, fwd_b
module hazard_unit
  import ctrl_pipe_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic       ex_beq,
  input  logic       ex_bne,
  input  logic       ex_zero,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_wreg,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_wreg,
  output logic       stall,
  output logic       flush,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b
);

  // A taken branch squashes the ID instruction anyway, so a load-use stall
  // raised in the same cycle is dropped rather than counted.
  always_comb begin
    logic load_use;
    logic take;
    load_use = ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (ex_rt == id_rt));
    take     = (ex_beq && ex_zero) || (ex_bne && !ex_zero);
    flush    = take;
    stall    = load_use && !take;
    fwd_a    = fwd_select(mem_reg_write, mem_wreg, wb_reg_write, wb_wreg, ex_rs);
    fwd_b    = fwd_select(mem_reg_write, mem_wreg, wb_reg_write, wb_wreg, ex_rt);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM and MEM/WB control registers for a 5-stage pipe.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : ctrl_pipe_if slave - ID-stage bundle and specifiers in,
//                EX/MEM/WB controls, hazard/forward selects and counters out
// Only the bundle fields a later stage consumes are carried past EX.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  ctrl_pipe_if.slave   bus
);

  ctrl_t       id_bundle;
  ctrl_t       ex_ctrl;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_wreg;

  logic        mem_mem_read;
  logic        mem_mem_write;
  logic        mem_reg_write;
  logic        mem_memto_reg;
  logic [4:0]  mem_wreg;

  logic        wb_reg_write;
  logic        wb_memto_reg;
  logic [4:0]  wb_wreg;

  logic        stall_w;
  logic        flush_w;
  fwd_sel_t    fwd_a_w;
  fwd_sel_t    fwd_b_w;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  assign id_bundle = ctrl_t'(bus.id_ctrl);
  assign ex_wreg   = ex_ctrl.reg_dst ? ex_rd : ex_rt;

  hazard_unit u_hazard (
    .ex_mem_read   (ex_ctrl.mem_read),
    .ex_beq        (ex_ctrl.beq),
    .ex_bne        (ex_ctrl.bne),
    .ex_zero       (bus.ex_zero),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .id_rs         (bus.id_rs),
    .id_rt         (bus.id_rt),
    .mem_reg_write (mem_reg_write),
    .mem_wreg      (mem_wreg),
    .wb_reg_write  (wb_reg_write),
    .wb_wreg       (wb_wreg),
    .stall         (stall_w),
    .flush         (flush_w),
    .fwd_a         (fwd_a_w),
    .fwd_b         (fwd_b_w)
  );

  // ID/EX: a stall or flush injects a fully zeroed bubble so stale
  // specifiers cannot trigger forwarding or load-use matches later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl <= CTRL_BUBBLE;
      ex_rs   <= '0;
      ex_rt   <= '0;
      ex_rd   <= '0;
    end else if (stall_w || flush_w) begin
      ex_ctrl <= CTRL_BUBBLE;
      ex_rs   <= '0;
      ex_rt   <= '0;
      ex_rd   <= '0;
    end else begin
      ex_ctrl <= id_bundle;
      ex_rs   <= bus.id_rs;
      ex_rt   <= bus.id_rt;
      ex_rd   <= bus.id_rd;
    end
  end

  // EX/MEM and MEM/WB advance unconditionally every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_memto_reg <= 1'b0;
      mem_wreg      <= '0;
      wb_reg_write  <= 1'b0;
      wb_memto_reg  <= 1'b0;
      wb_wreg       <= '0;
    end else begin
      mem_mem_read  <= ex_ctrl.mem_read;
      mem_mem_write <= ex_ctrl.mem_write;
      mem_reg_write <= ex_ctrl.reg_write;
      mem_memto_reg <= ex_ctrl.memto_reg;
      mem_wreg      <= ex_wreg;
      wb_reg_write  <= mem_reg_write;
      wb_memto_reg  <= mem_memto_reg;
      wb_wreg       <= mem_wreg;
    end
  end

  // Event counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_w && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (flush_w && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign bus.ex_ALUOp     = ex_ctrl.alu_op;
  assign bus.ex_ALUSrc    = ex_ctrl.alu_src;
  assign bus.ex_rs        = ex_rs;
  assign bus.ex_rt        = ex_rt;
  assign bus.mem_memRead  = mem_mem_read;
  assign bus.mem_memWrite = mem_mem_write;
  assign bus.wb_regWrite  = wb_reg_write;
  assign bus.wb_memtoReg  = wb_memto_reg;
  assign bus.wb_wreg      = wb_wreg;
  assign bus.stall        = stall_w;
  assign bus.flush        = flush_w;
  assign bus.fwd_a        = fwd_a_w;
  assign bus.fwd_b        = fwd_b_w;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: self-checking bench for ctrl_pipe.
// A table of instructions is streamed through the pipe; each entry's EX,
// MEM and WB expectations ride a queue per stage and are checked as the
// entry reaches that stage. Hazard corner cases follow as short sequences.
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

  // Bundle order: regDst memRead memtoReg memWrite ALUSrc regWrite beq bne ALUOp[2:0]
  localparam logic [10:0] C_NOP   = 11'b00000000000;
  localparam logic [10:0] C_RTYPE = 11'b10000100010;
  localparam logic [10:0] C_SW    = 11'b00011000000;
  localparam logic [10:0] C_ORI   = 11'b00001100011;
  localparam logic [10:0] C_LW    = 11'b01101100000;
  localparam logic [10:0] C_SLTI  = 11'b00001100100;
  localparam logic [10:0] C_BEQ   = 11'b00000010001;
  localparam logic [10:0] C_BNE   = 11'b00000001001;
  localparam logic [10:0] C_JUMP  = 11'b00000000111;
  localparam logic [10:0] C_LWBEQ = 11'b01000010001;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ctrl_pipe_if bus ();

  ctrl_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [2:0]  ex_op;
    logic        ex_src;
    logic        mem_rd;
    logic        mem_wr;
    logic        wb_rw;
    logic        wb_m2r;
    logic [4:0]  wb_wreg;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } vec_t;

  vec_t vecs[13];
  int   ex_q[$];
  int   mem_q[$];
  int   wb_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [10:0] c, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic z);
    bus.id_ctrl = c;
    bus.id_rs   = rs;
    bus.id_rt   = rt;
    bus.id_rd   = rd;
    bus.ex_zero = z;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " ex_ALUOp"},     32'(bus.ex_ALUOp), 0);
    checkOutput({tag, " ex_ALUSrc"},    32'(bus.ex_ALUSrc), 0);
    checkOutput({tag, " ex_rs"},        32'(bus.ex_rs), 0);
    checkOutput({tag, " ex_rt"},        32'(bus.ex_rt), 0);
    checkOutput({tag, " mem_memRead"},  32'(bus.mem_memRead), 0);
    checkOutput({tag, " mem_memWrite"}, 32'(bus.mem_memWrite), 0);
    checkOutput({tag, " wb_regWrite"},  32'(bus.wb_regWrite), 0);
    checkOutput({tag, " wb_memtoReg"},  32'(bus.wb_memtoReg), 0);
    checkOutput({tag, " wb_wreg"},      32'(bus.wb_wreg), 0);
    checkOutput({tag, " stall"},        32'(bus.stall), 0);
    checkOutput({tag, " flush"},        32'(bus.flush), 0);
    checkOutput({tag, " fwd_a"},        32'(bus.fwd_a), 0);
    checkOutput({tag, " fwd_b"},        32'(bus.fwd_b), 0);
    checkOutput({tag, " stall_cnt"},    32'(bus.stall_cnt), 0);
    checkOutput({tag, " flush_cnt"},    32'(bus.flush_cnt), 0);
  endtask

  // Called just after each edge: retire WB, advance MEM->WB, then EX->MEM.
  task automatic scoreCycle();
    int i;
    if (wb_q.size() > 0) begin
      i = wb_q.pop_front();
      checkOutput($sformatf("v%0d wb_regWrite", i), 32'(bus.wb_regWrite), 32'(vecs[i].wb_rw));
      checkOutput($sformatf("v%0d wb_memtoReg", i), 32'(bus.wb_memtoReg), 32'(vecs[i].wb_m2r));
      checkOutput($sformatf("v%0d wb_wreg", i),     32'(bus.wb_wreg), 32'(vecs[i].wb_wreg));
    end
    if (mem_q.size() > 0) begin
      i = mem_q.pop_front();
      checkOutput($sformatf("v%0d mem_memRead", i),  32'(bus.mem_memRead), 32'(vecs[i].mem_rd));
      checkOutput($sformatf("v%0d mem_memWrite", i), 32'(bus.mem_memWrite), 32'(vecs[i].mem_wr));
      wb_q.push_back(i);
    end
    if (ex_q.size() > 0) begin
      i = ex_q.pop_front();
      checkOutput($sformatf("v%0d ex_ALUOp", i),  32'(bus.ex_ALUOp), 32'(vecs[i].ex_op));
      checkOutput($sformatf("v%0d ex_ALUSrc", i), 32'(bus.ex_ALUSrc), 32'(vecs[i].ex_src));
      checkOutput($sformatf("v%0d ex_rs", i),     32'(bus.ex_rs), 32'(vecs[i].rs));
      checkOutput($sformatf("v%0d ex_rt", i),     32'(bus.ex_rt), 32'(vecs[i].rt));
      checkOutput($sformatf("v%0d fwd_a", i),     32'(bus.fwd_a), 32'(vecs[i].fa));
      checkOutput($sformatf("v%0d fwd_b", i),     32'(bus.fwd_b), 32'(vecs[i].fb));
      mem_q.push_back(i);
    end
  endtask

  initial begin
    //           ctrl     rs     rt      rd     op    src   mrd   mwr   rw    m2r   wreg    fa     fb
    vecs[0]  = '{C_RTYPE, 5'd1,  5'd2,  5'd3,  3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3,  2'd0,  2'd0};
    vecs[1]  = '{C_SW,    5'd3,  5'd4,  5'd9,  3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4,  2'd2,  2'd0};
    vecs[2]  = '{C_ORI,   5'd3,  5'd6,  5'd0,  3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6,  2'd1,  2'd0};
    vecs[3]  = '{C_LW,    5'd6,  5'd7,  5'd0,  3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7,  2'd2,  2'd0};
    vecs[4]  = '{C_RTYPE, 5'd6,  5'd9,  5'd7,  3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7,  2'd1,  2'd0};
    vecs[5]  = '{C_SLTI,  5'd7,  5'd11, 5'd0,  3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd11, 2'd2,  2'd0};
    vecs[6]  = '{C_BEQ,   5'd7,  5'd11, 5'd0,  3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11, 2'd1,  2'd2};
    vecs[7]  = '{C_JUMP,  5'd0,  5'd0,  5'd0,  3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  2'd0,  2'd0};
    vecs[8]  = '{C_RTYPE, 5'd1,  5'd2,  5'd0,  3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  2'd0,  2'd0};
    vecs[9]  = '{C_RTYPE, 5'd0,  5'd0,  5'd5,  3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5,  2'd0,  2'd0};
    vecs[10] = '{C_NOP,   5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  2'd0,  2'd0};
    vecs[11] = '{C_NOP,   5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  2'd0,  2'd0};
    vecs[12] = '{C_NOP,   5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  2'd0,  2'd0};

    rst_n = 1'b0;
    applyStimulus(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] streaming instruction table");
    for (int v = 0; v < 13; v++) begin
      applyStimulus(vecs[v].ctrl, vecs[v].rs, vecs[v].rt, vecs[v].rd, 1'b0);
      ex_q.push_back(v);
      #1;
      checkOutput($sformatf("v%0d stall", v), 32'(bus.stall), 0);
      checkOutput($sformatf("v%0d flush", v), 32'(bus.flush), 0);
      tick();
      scoreCycle();
    end
    for (int d = 0; d < 4 && (ex_q.size() + mem_q.size() + wb_q.size()) > 0; d++) begin
      applyStimulus(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      scoreCycle();
    end
    checkOutput("scoreboard drained", 32'(ex_q.size() + mem_q.size() + wb_q.size()), 0);

    $display("[TB] load-use stall");
    applyStimulus(C_LW, 5'd1, 5'd5, 5'd0, 1'b0);
    tick();
    applyStimulus(C_RTYPE, 5'd5, 5'd2, 5'd8, 1'b0);
    #1;
    checkOutput("lw-use stall", 32'(bus.stall), 1);
    checkOutput("lw-use flush", 32'(bus.flush), 0);
    tick();
    checkOutput("lw-use bubble ALUOp", 32'(bus.ex_ALUOp), 0);
    checkOutput("lw-use bubble ALUSrc", 32'(bus.ex_ALUSrc), 0);
    checkOutput("lw-use lw in MEM", 32'(bus.mem_memRead), 1);
    checkOutput("lw-use stall_cnt", 32'(bus.stall_cnt), 1);
    #1;
    checkOutput("lw-use stall released", 32'(bus.stall), 0);
    tick();
    checkOutput("lw-use consumer ALUOp", 32'(bus.ex_ALUOp), 2);
    checkOutput("lw-use consumer rs", 32'(bus.ex_rs), 5);
    checkOutput("lw-use bubble in MEM", 32'(bus.mem_memRead), 0);
    checkOutput("lw-use fwd_a from WB", 32'(bus.fwd_a), 1);
    checkOutput("lw-use wb_memtoReg", 32'(bus.wb_memtoReg), 1);
    checkOutput("lw-use stall_cnt held", 32'(bus.stall_cnt), 1);

    $display("[TB] branches");
    applyStimulus(C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    applyStimulus(C_RTYPE, 5'd3, 5'd4, 5'd6, 1'b1);
    #1;
    checkOutput("beq taken flush", 32'(bus.flush), 1);
    checkOutput("beq taken stall", 32'(bus.stall), 0);
    tick();
    checkOutput("beq taken bubble ALUOp", 32'(bus.ex_ALUOp), 0);
    checkOutput("beq taken flush_cnt", 32'(bus.flush_cnt), 1);
    #1;
    checkOutput("flush after bubble", 32'(bus.flush), 0);

    applyStimulus(C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    applyStimulus(C_RTYPE, 5'd3, 5'd4, 5'd6, 1'b0);
    #1;
    checkOutput("beq not taken flush", 32'(bus.flush), 0);
    tick();
    checkOutput("beq not taken ALUOp", 32'(bus.ex_ALUOp), 2);
    checkOutput("beq not taken flush_cnt", 32'(bus.flush_cnt), 1);

    applyStimulus(C_BNE, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    applyStimulus(C_RTYPE, 5'd3, 5'd4, 5'd6, 1'b0);
    #1;
    checkOutput("bne taken flush", 32'(bus.flush), 1);
    tick();
    checkOutput("bne taken flush_cnt", 32'(bus.flush_cnt), 2);
    checkOutput("bne taken bubble ALUOp", 32'(bus.ex_ALUOp), 0);

    applyStimulus(C_LWBEQ, 5'd1, 5'd5, 5'd0, 1'b0);
    tick();
    applyStimulus(C_RTYPE, 5'd5, 5'd2, 5'd8, 1'b1);
    #1;
    checkOutput("flush-wins flush", 32'(bus.flush), 1);
    checkOutput("flush-wins stall", 32'(bus.stall), 0);
    tick();
    checkOutput("flush-wins stall_cnt", 32'(bus.stall_cnt), 1);
    checkOutput("flush-wins flush_cnt", 32'(bus.flush_cnt), 3);

    $display("[TB] counter saturation");
    applyStimulus(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    force dut.stall_w = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    release dut.stall_w;
    checkOutput("stall_cnt saturated", 32'(bus.stall_cnt), 32'h0000FFFF);
    checkOutput("flush_cnt untouched", 32'(bus.flush_cnt), 3);

    $display("[TB] asynchronous reset mid-pipeline");
    applyStimulus(C_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    applyStimulus(C_RTYPE, 5'd3, 5'd2, 5'd4, 1'b0);
    tick();
    applyStimulus(C_LW, 5'd3, 5'd9, 5'd0, 1'b0);
    tick();
    checkOutput("pre-reset fwd_a", 32'(bus.fwd_a), 1);
    applyStimulus(C_RTYPE, 5'd9, 5'd1, 5'd7, 1'b0);
    #1;
    checkOutput("pre-reset stall", 32'(bus.stall), 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkReset("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("post-reset ALUOp", 32'(bus.ex_ALUOp), 2);
    checkOutput("post-reset ex_rs", 32'(bus.ex_rs), 9);
    checkOutput("post-reset ex_rt", 32'(bus.ex_rt), 1);
    checkOutput("post-reset stall", 32'(bus.stall), 0);
    checkOutput("post-reset stall_cnt", 32'(bus.stall_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have a single clock, and reset SHALL be asynchronous and active-low.
REQ-002 SHALL provide these clock and reset ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.

REQ-003 SHALL provide these ID-stage inputs:
- id_ctrl  in  11  decoded control bundle {regDst, memRead, memtoReg, memWrite, ALUSrc, regWrite, beq, bne, ALUOp[2:0]}.
- id_rs, id_rt, id_rd  in  5 each  ID-stage register specifiers.
- ex_zero  in  1  ALU zero flag for the instruction in EX.

REQ-004 SHALL provide these EX-stage outputs:
- ex_ALUOp  out  3  EX ALU operation.
- ex_ALUSrc  out  1  EX ALU operand-B select.
- ex_rs, ex_rt  out  5 each  EX-stage source specifiers.

REQ-005 SHALL provide these MEM- and WB-stage outputs:
- mem_memRead, mem_memWrite  out  1 each  data-memory strobes.
- wb_regWrite, wb_memtoReg  out  1 each  writeback controls.
- wb_wreg  out  5  writeback destination register.

REQ-006 SHALL provide these hazard, forwarding and counter outputs:
- stall  out  1  hold PC and IF/ID; combinational.
- flush  out  1  squash IF/ID; combinational.
- fwd_a, fwd_b  out  2 each  ALU operand forward selects.
- stall_cnt, flush_cnt  out  16 each  event counters.

Function
REQ-007 SHALL hold three registered stages (ID/EX, EX/MEM, MEM/WB); each stage advances on every rising clk edge.
- Bubble: all control bits 0 and ALUOp 3'b000.
- Each bundle SHALL emerge in EX 1 cycle after ID, in MEM after 2 cycles and in WB after 3 cycles.
REQ-008 SHALL compute the EX write register: ex_wreg = regDst ? ex_rd : ex_rt. This value SHALL be carried into EX/MEM and then MEM/WB.
REQ-009 SHALL compute the load-use hazard: stall = ex_memRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
REQ-010 SHALL compute branch taken: take = (ex_beq & ex_zero) | (ex_bne & ~ex_zero); flush = take.
REQ-011 On an edge with stall=1 or flush=1, ID/EX SHALL load a bubble; otherwise it SHALL load id_ctrl and the specifiers.
REQ-012 EX/MEM and MEM/WB SHALL never stall.
REQ-013 When stall and flush are both 1, flush SHALL win and stall SHALL be forced to 0.
REQ-014 fwd_a SHALL be:
- 2'b10 if mem_regWrite & (mem_wreg != 0) & (mem_wreg == ex_rs);
- else 2'b01 if wb_regWrite & (wb_wreg != 0) & (wb_wreg == ex_rs);
- else 2'b00.
REQ-015 fwd_b SHALL use the REQ-014 rule with ex_rt in place of ex_rs.
REQ-016 stall_cnt SHALL increment on each edge with stall=1, and flush_cnt on each edge with flush=1. Both SHALL saturate at 16'hFFFF and never wrap.
REQ-017 ALUOp 3'b111 (jump) SHALL pass through as ordinary data, with no hazard action.

Reset
REQ-018 When rst_n=0, all stage registers SHALL immediately become bubbles and both counters 0, independent of clk.
REQ-019 While in reset, stall, flush, fwd_a and fwd_b SHALL be 0.
REQ-020 Reset asserted mid-stall SHALL discard the pending bubble. The first post-reset edge SHALL load id_ctrl normally.

Structure
REQ-021 A shared package SHALL hold:
- the control-bundle typedef and the bubble constant;
- the ALUOp encodings 000/001/010/011/100/111;
- the forward-select encodings 00/01/10.
REQ-022 Hazard and forwarding logic SHALL be one sub-module, hazard_unit; the stage registers SHALL stay in ctrl_pipe.

Verification
REQ-023 SHALL cover these directed scenarios:
- Stream R-type (id_ctrl regDst=1, regWrite=1, ALUOp=010) -> wb_regWrite=1 three edges later; wb_wreg=id_rd.
- lw $5 followed by an ID-stage instruction with id_rs=5 -> stall=1 for exactly 1 cycle, ID/EX bubble, stall_cnt=1.
- beq in EX with ex_zero=1 -> flush=1, next ID/EX bubble, flush_cnt=1.
- beq in EX with ex_zero=0 -> flush=0.
- Same beq case with a simultaneous load-use match -> flush=1, stall=0, stall_cnt unchanged.
- MEM and WB both writing $7, ex_rs=7 -> fwd_a=10.
- Only WB writing $7 -> fwd_a=01.
- Writes to $0 -> fwd_a=00.
- Force stall 65540 cycles -> stall_cnt=FFFF.
- Assert rst_n=0 asynchronously mid-pipeline -> all outputs 0 before the next clk edge.
